// File: rtl/priority_request_latch_if.sv
// Bus between the request latch, its 4:2 priority encoder and the interrupt consumer.
// The latch sits on the slave side; whoever drives requests/acks uses master.
interface priority_request_latch_if;
    logic [3:0] req;
    logic [3:0] mask;
    logic [1:0] code;
    logic       ack;
    logic       ovf_clr;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [3:0] pending;
    logic       irq;
    logic       overflow;

    modport master (
        output req, mask, code, ack, ovf_clr,
        input  a, b, c, d, pending, irq, overflow
    );

    modport slave (
        input  req, mask, code, ack, ovf_clr,
        output a, b, c, d, pending, irq, overflow
    );
endinterface

// File: rtl/priority_request_latch.sv
// Latches rising request edges into sticky pending bits for the priority encoder,
// raises irq to the consumer and clears the encoded bit on ack, then holds off.
module priority_request_latch #(
    parameter int HOLDOFF_CYCLES = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    priority_request_latch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOTIFY  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      req_q;
    logic [3:0]      pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic            irq_q, irq_d;

    logic [3:0]      rise;
    logic [3:0]      unmasked;
    logic            any_unmasked;
    logic            ack_take;
    logic [3:0]      clr;

    assign rise         = bus.req & ~req_q;
    assign unmasked     = pending_q & ~bus.mask;
    assign any_unmasked = |unmasked;
    assign clr          = ack_take ? (4'b0001 << bus.code) : 4'b0000;

    assign bus.a        = unmasked[0];
    assign bus.b        = unmasked[1];
    assign bus.c        = unmasked[2];
    assign bus.d        = unmasked[3];
    assign bus.pending  = pending_q;
    assign bus.irq      = irq_q;
    assign bus.overflow = overflow_q;

    // A fresh edge beats a same-cycle clear, so a request is never lost to an ack.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) begin
                pending_d[i] = 1'b1;
            end else if (clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        overflow_d = overflow_q;
        if (|(rise & pending_q & ~clr)) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ack_take   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_unmasked) begin
                    state_d = NOTIFY;
                end
            end
            NOTIFY: begin
                // code is only meaningful while something unmasked is pending.
                if (!any_unmasked) begin
                    state_d = IDLE;
                end else if (bus.ack) begin
                    ack_take   = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        irq_d = (state_d == NOTIFY);
    end

    // Levels already high at reset release show up as rises on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            req_q      <= 4'b0000;
            pending_q  <= 4'b0000;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            req_q      <= bus.req;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    irqMatchesState: assert property (@(posedge clk) disable iff (!rst_n)
        irq_q == (state_q == NOTIFY));

    stateLegal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q != 2'd3);

endmodule

// File: tb/tb_priority_request_latch.sv
// Directed, table-driven bench for priority_request_latch with HOLDOFF_CYCLES=2,
// plus hand-written sequences for reset-in-holdoff and mask-with-ack.
module tb_priority_request_latch;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic [1:0] code;
        logic       ack;
        logic       ovfClr;
        logic [3:0] expPending;
        logic       expIrq;
        logic       expOvf;
        logic [3:0] expAbcd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    vec_t vecs[$];

    priority_request_latch_if bus ();

    priority_request_latch #(.HOLDOFF_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] pend, input logic irq,
                            input logic ovf, input logic [3:0] abcd);
        checkOutput({tag, " pending"},  bus.pending, pend);
        checkOutput({tag, " irq"},      {3'b000, bus.irq}, {3'b000, irq});
        checkOutput({tag, " overflow"}, {3'b000, bus.overflow}, {3'b000, ovf});
        checkOutput({tag, " abcd"},     {bus.d, bus.c, bus.b, bus.a}, abcd);
    endtask

    task automatic driveInputs(input logic [3:0] req, input logic [3:0] mask, input logic [1:0] code,
                               input logic ack, input logic ovfClr);
        bus.req     = req;
        bus.mask    = mask;
        bus.code    = code;
        bus.ack     = ack;
        bus.ovf_clr = ovfClr;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        driveInputs(v.req, v.mask, v.code, v.ack, v.ovfClr);
        @(posedge clk);
        #1;
        checkAll($sformatf("row%0d", idx), v.expPending, v.expIrq, v.expOvf, v.expAbcd);
    endtask

    task automatic addVec(input logic [3:0] req, input logic [3:0] mask, input logic [1:0] code,
                          input logic ack, input logic ovfClr, input logic [3:0] pend,
                          input logic irq, input logic ovf, input logic [3:0] abcd);
        vec_t v;
        v.req = req; v.mask = mask; v.code = code; v.ack = ack; v.ovfClr = ovfClr;
        v.expPending = pend; v.expIrq = irq; v.expOvf = ovf; v.expAbcd = abcd;
        vecs.push_back(v);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        //     req      mask     code  ack   clr   pending  irq   ovf   abcd
        // single request, ack, holdoff
        addVec(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100);
        addVec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100);
        addVec(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // two requests, highest acked first, holdoff then re-notify
        addVec(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001);
        addVec(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 4'b1001);
        addVec(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 4'b1001);
        addVec(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // overflow set, sticky, set beats clear, then clear
        addVec(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010);
        addVec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010);
        addVec(4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010);
        addVec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010);
        addVec(4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010);
        addVec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010);
        addVec(4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // mask withdraws irq without touching pending
        addVec(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100);
        addVec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100);
        addVec(4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100);
        // ack and rise on the same bit: rise wins, no overflow; ack in holdoff ignored
        addVec(4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100);
        addVec(4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100);
        addVec(4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100);
        addVec(4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100);
        addVec(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        addVec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);

        rst_n = 1'b0;
        driveInputs(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        #2;
        checkAll("reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
        end

        // Reset pulsed during HOLDOFF with all requests held high.
        @(negedge clk);
        driveInputs(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkAll("allReq", 4'b1111, 1'b0, 1'b0, 4'b1111);
        @(negedge clk);
        driveInputs(4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkAll("allNotify", 4'b1111, 1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        driveInputs(4'b1111, 4'b0000, 2'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkAll("allAck", 4'b0111, 1'b0, 1'b0, 4'b0111);
        @(negedge clk);
        driveInputs(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("midReset", 4'b0000, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkAll("postReset", 4'b1111, 1'b0, 1'b0, 4'b1111);
        @(posedge clk); #1;
        checkAll("postResetIrq", 4'b1111, 1'b1, 1'b0, 4'b1111);

        // Mask everything while acking: encoder inputs drop at once, ack ignored.
        @(negedge clk);
        driveInputs(4'b1111, 4'b1111, 2'd3, 1'b1, 1'b0);
        #1;
        checkAll("maskComb", 4'b1111, 1'b1, 1'b0, 4'b0000);
        @(posedge clk); #1;
        checkAll("maskAck", 4'b1111, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        driveInputs(4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkAll("unmask", 4'b1111, 1'b1, 1'b0, 4'b1111);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
